mem_req_initiator: RTL and testbench

//  Initiator for one port of the dual-port block memory (addr/din/en/we out, dout in).
//  - Converts a valid/ready request stream (load/store) into memory-port cycles.
//  - Tracks the fixed read latency and returns load data on a valid/ready response

---
 rtl/mem_pkg.sv | 24 ++
 rtl/mem_resp_fifo.sv | 63 ++++++
 rtl/mem_req_initiator.sv | 117 +++++++++++
 tb/tb_mem_req_initiator.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types, defaults and pointer helper for the block-memory request initiator.
package mem_pkg;

  localparam int READ_LATENCY_DEF = 2;
  localparam int ADDR_W_DEF       = 32;
  localparam int DATA_W_DEF       = 32;

  typedef struct packed {
    logic                  we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } mem_req_t;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] rdata;
    logic                  is_write;
  } resp_t;

  // Pointer increment that wraps at an arbitrary (not only power-of-two) depth.
  function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/mem_resp_fifo.sv
// First-word-fall-through response FIFO; pointers wrap modulo DEPTH so any depth works.
module mem_resp_fifo
  import mem_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int W     = 32,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [W-1:0]     wdata_i,
  input  logic             pop_i,
  output logic [W-1:0]     rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push_s, do_pop_s;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign count_o   = count_q;
  assign rdata_o   = mem_q[rd_ptr_q];
  assign do_pop_s  = pop_i && !empty_o;
  // A push into a full FIFO is accepted only when the same cycle frees a slot.
  assign do_push_s = push_i && (!full_o || do_pop_s);

  always_comb begin
    wr_ptr_d = do_push_s ? PTR_W'(wrap_inc(32'(wr_ptr_q), 32'(DEPTH))) : wr_ptr_q;
    rd_ptr_d = do_pop_s  ? PTR_W'(wrap_inc(32'(rd_ptr_q), 32'(DEPTH))) : rd_ptr_q;
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/mem_req_initiator.sv
// Valid/ready to block-memory port initiator with latency tracking and credit-protected response FIFO.
// Optional MEM_INIT_WRITE_ACK_EN: stores also return an ordered ack (rdata '0, resp_is_write=1).
module mem_req_initiator
  import mem_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = READ_LATENCY_DEF,
  parameter int RESP_DEPTH   = 4
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_en,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              idle
`ifdef MEM_INIT_WRITE_ACK_EN
  ,
  output logic              resp_is_write
`endif
);

  localparam int CNT_W = $clog2(RESP_DEPTH + 1);
  // The issue cycle is the first latency stage, so only READ_LATENCY-1 stages are registered.
  localparam int SR_W  = (READ_LATENCY > 1) ? READ_LATENCY - 1 : 1;
`ifdef MEM_INIT_WRITE_ACK_EN
  localparam int FIFO_W = DATA_W + 1;
`else
  localparam int FIFO_W = DATA_W;
`endif

  logic              issue_s, resp_issue_s, exit_s;
  logic [SR_W-1:0]   lat_sr_q, lat_sr_d;
  logic [CNT_W-1:0]  inflight_q, inflight_d;
  logic [CNT_W-1:0]  fifo_count_s;
  logic [CNT_W:0]    used_s;
  logic              fifo_full_s, fifo_empty_s, fifo_pop_s;
  logic [FIFO_W-1:0] fifo_wdata_s, fifo_rdata_s;

  // Credits depend only on counters, never on the request itself.
  assign used_s    = {1'b0, inflight_q} + {1'b0, fifo_count_s};
  assign req_ready = !rst && !fifo_full_s && (used_s < (CNT_W + 1)'(RESP_DEPTH));

  assign issue_s  = req_valid && req_ready;
  assign mem_en   = issue_s;
  assign mem_we   = issue_s && req_we;
  assign mem_addr = req_addr;
  assign mem_din  = req_wdata;

`ifdef MEM_INIT_WRITE_ACK_EN
  logic [SR_W-1:0] wr_sr_q, wr_sr_d;
  logic            exit_wr_s;

  assign resp_issue_s = issue_s;
  assign exit_wr_s    = (READ_LATENCY == 1) ? req_we : wr_sr_q[SR_W-1];
  assign wr_sr_d      = (wr_sr_q << 1) | SR_W'(issue_s && req_we);
  assign fifo_wdata_s = {exit_wr_s, (exit_wr_s ? DATA_W'(0) : mem_dout)};
  assign resp_is_write = fifo_rdata_s[DATA_W];

  always_ff @(posedge clock) begin
    if (rst) begin
      wr_sr_q <= '0;
    end else begin
      wr_sr_q <= wr_sr_d;
    end
  end
`else
  assign resp_issue_s = issue_s && !req_we;
  assign fifo_wdata_s = mem_dout;
`endif

  assign exit_s     = (READ_LATENCY == 1) ? resp_issue_s : lat_sr_q[SR_W-1];
  assign lat_sr_d   = (lat_sr_q << 1) | SR_W'(resp_issue_s);
  assign inflight_d = inflight_q + CNT_W'(resp_issue_s) - CNT_W'(exit_s);

  always_ff @(posedge clock) begin
    if (rst) begin
      lat_sr_q   <= '0;
      inflight_q <= '0;
    end else begin
      lat_sr_q   <= lat_sr_d;
      inflight_q <= inflight_d;
    end
  end

  assign fifo_pop_s = resp_valid && resp_ready;

  mem_resp_fifo #(
    .DEPTH (RESP_DEPTH),
    .W     (FIFO_W)
  ) u_fifo (
    .clk_i   (clock),
    .rst_i   (rst),
    .push_i  (exit_s),
    .wdata_i (fifo_wdata_s),
    .pop_i   (fifo_pop_s),
    .rdata_o (fifo_rdata_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (fifo_count_s)
  );

  assign resp_valid = !fifo_empty_s;
  assign resp_rdata = fifo_rdata_s[DATA_W-1:0];
  assign idle       = (inflight_q == '0) && fifo_empty_s;

endmodule

// File: tb/tb_mem_req_initiator.sv
// Directed self-checking bench for mem_req_initiator with a block-memory model
// (dout valid one cycle after issue, captured on the second edge: READ_LATENCY=2).
module tb_mem_req_initiator;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst, req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_rdata, mem_addr, mem_din, mem_dout;
  logic        mem_en, mem_we, idle;
`ifdef MEM_INIT_WRITE_ACK_EN
  logic        resp_is_write;
`endif

  int tests_run    = 0;
  int tests_failed = 0;
  bit overflow_seen = 1'b0;

  mem_req_initiator dut (
    .clock      (clock),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_dout   (mem_dout),
    .idle       (idle)
`ifdef MEM_INIT_WRITE_ACK_EN
    ,
    .resp_is_write (resp_is_write)
`endif
  );

  // Memory model: unwritten word a reads as 0xC0DE0000 + a.
  logic [31:0] wmem [256];
  bit          wvalid [256];
  logic [31:0] rd_q = 32'h0;
  always @(posedge clock) begin
    if (mem_en && mem_we) begin
      wmem[mem_addr[7:0]]   <= mem_din;
      wvalid[mem_addr[7:0]] <= 1'b1;
    end
    if (mem_en && !mem_we)
      rd_q <= wvalid[mem_addr[7:0]] ? wmem[mem_addr[7:0]] : (32'hC0DE0000 + {24'h0, mem_addr[7:0]});
  end
  assign mem_dout = rd_q;

  always @(posedge clock)
    if (!rst && dut.u_fifo.push_i && dut.u_fifo.full_o && !dut.u_fifo.pop_i) overflow_seen = 1'b1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_wdata = 32'h0; resp_ready = 1'b1;
    next_cycle(); next_cycle();
    @(negedge clock);
    tests_run++; if (req_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
    tests_run++; if (mem_en !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_en: got %b expected 0", mem_en); end
    tests_run++; if (mem_we !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
    tests_run++; if (resp_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    tests_run++; if (idle !== 1'b1) begin tests_failed++; $display("FAIL reset_idle: got %b expected 1", idle); end
    next_cycle();
    rst = 1'b0; req_valid = 1'b0;
  endtask

  task automatic test_load_latency();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; resp_ready = 1'b1;
    @(negedge clock);
    tests_run++; if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL load_req_ready: got %b expected 1", req_ready); end
    tests_run++; if ({mem_en, mem_we} !== 2'b10) begin tests_failed++; $display("FAIL load_en_we: got %b expected 10", {mem_en, mem_we}); end
    tests_run++; if (mem_addr !== 32'h10) begin tests_failed++; $display("FAIL load_mem_addr: got %h expected 00000010", mem_addr); end
    next_cycle();
    req_valid = 1'b0;
    @(negedge clock);
    tests_run++; if ({resp_valid, idle} !== 2'b00) begin tests_failed++; $display("FAIL load_cycle1: got valid,idle=%b expected 00", {resp_valid, idle}); end
    next_cycle();
    @(negedge clock);
    tests_run++; if (resp_valid !== 1'b1) begin tests_failed++; $display("FAIL load_cycle2_valid: got %b expected 1", resp_valid); end
    tests_run++; if (resp_rdata !== 32'hC0DE0010) begin tests_failed++; $display("FAIL load_rdata: got %h expected c0de0010", resp_rdata); end
    next_cycle();
    @(negedge clock);
    tests_run++; if ({resp_valid, idle} !== 2'b01) begin tests_failed++; $display("FAIL load_drained: got valid,idle=%b expected 01", {resp_valid, idle}); end
  endtask

  task automatic test_store_load();
    logic exp_c2_valid;
`ifdef MEM_INIT_WRITE_ACK_EN
    exp_c2_valid = 1'b1;
`else
    exp_c2_valid = 1'b0;
`endif
    next_cycle();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hDEADBEEF; resp_ready = 1'b1;
    @(negedge clock);
    tests_run++; if ({mem_en, mem_we} !== 2'b11) begin tests_failed++; $display("FAIL store_en_we: got %b expected 11", {mem_en, mem_we}); end
    tests_run++; if (mem_din !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL store_din: got %h expected deadbeef", mem_din); end
    next_cycle();
    req_we = 1'b0;
    @(negedge clock);
    tests_run++; if ({mem_en, mem_we} !== 2'b10) begin tests_failed++; $display("FAIL store_load_en_we: got %b expected 10", {mem_en, mem_we}); end
    next_cycle();
    req_valid = 1'b0;
    @(negedge clock);
    tests_run++; if (resp_valid !== exp_c2_valid) begin tests_failed++; $display("FAIL store_no_resp: got %b expected %b", resp_valid, exp_c2_valid); end
    next_cycle();
    @(negedge clock);
    tests_run++; if ({resp_valid, resp_rdata} !== {1'b1, 32'hDEADBEEF}) begin tests_failed++; $display("FAIL store_load_rdata: got %b/%h expected 1/deadbeef", resp_valid, resp_rdata); end
    next_cycle();
  endtask

  task automatic test_backpressure();
    int acc = 0;
    int got = 0;
    bit a;
    resp_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h40 + acc;
      @(negedge clock);
      a = req_ready;
      next_cycle();
      if (a) acc++;
    end
    @(negedge clock);
    tests_run++; if (acc !== 4) begin tests_failed++; $display("FAIL bp_accepted: got %0d expected 4", acc); end
    tests_run++; if (req_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_ready_low: got %b expected 0", req_ready); end
    next_cycle();
    resp_ready = 1'b1;
    for (int c = 0; c < 60 && got < 6; c++) begin
      req_valid = (acc < 6); req_addr = 32'h40 + acc;
      @(negedge clock);
      a = req_valid && req_ready;
      if (resp_valid) begin
        tests_run++; if (resp_rdata !== 32'hC0DE0040 + got) begin tests_failed++; $display("FAIL bp_order[%0d]: got %h expected %h", got, resp_rdata, 32'hC0DE0040 + got); end
        got++;
      end
      next_cycle();
      if (a) acc++;
    end
    req_valid = 1'b0;
    tests_run++; if (got !== 6 || acc !== 6) begin tests_failed++; $display("FAIL bp_totals: got resp=%0d acc=%0d expected 6/6", got, acc); end
  endtask

  task automatic test_back_to_back();
    int got = 0;
    int stalls = 0;
    resp_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      req_valid = (c < 8); req_we = 1'b0; req_addr = 32'h50 + c;
      @(negedge clock);
      if (req_valid && !req_ready) stalls++;
      if (resp_valid) begin
        tests_run++; if (resp_rdata !== 32'hC0DE0050 + got || c !== got + 2) begin tests_failed++; $display("FAIL b2b_resp[%0d]: got %h at cycle %0d expected %h at cycle %0d", got, resp_rdata, c, 32'hC0DE0050 + got, got + 2); end
        got++;
      end
      next_cycle();
    end
    req_valid = 1'b0;
    tests_run++; if (stalls !== 0 || got !== 8) begin tests_failed++; $display("FAIL b2b_totals: got stalls=%0d resp=%0d expected 0/8", stalls, got); end
  endtask

  task automatic test_full_fifo();
    int acc = 0;
    int got = 0;
    bit pending = 1'b1;
    bit a;
    resp_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      req_valid = (acc < 4); req_we = 1'b0; req_addr = 32'h60 + acc;
      @(negedge clock);
      a = req_valid && req_ready;
      next_cycle();
      if (a) acc++;
    end
    req_valid = 1'b0;
    @(negedge clock);
    tests_run++; if (dut.u_fifo.count_o !== 3'd4) begin tests_failed++; $display("FAIL full_count: got %0d expected 4", dut.u_fifo.count_o); end
    tests_run++; if ({resp_valid, resp_rdata} !== {1'b1, 32'hC0DE0060}) begin tests_failed++; $display("FAIL full_head: got %b/%h expected 1/c0de0060", resp_valid, resp_rdata); end
    next_cycle();
    resp_ready = 1'b1;
    for (int c = 0; c < 30 && got < 5; c++) begin
      req_valid = pending; req_addr = 32'h64;
      @(negedge clock);
      if (c == 0) begin
        tests_run++; if (req_ready !== 1'b0) begin tests_failed++; $display("FAIL full_ready_on_pop: got %b expected 0", req_ready); end
      end
      a = req_valid && req_ready;
      if (resp_valid) begin
        tests_run++; if (resp_rdata !== 32'hC0DE0060 + got) begin tests_failed++; $display("FAIL full_order[%0d]: got %h expected %h", got, resp_rdata, 32'hC0DE0060 + got); end
        got++;
      end
      next_cycle();
      if (a) pending = 1'b0;
    end
    req_valid = 1'b0;
    tests_run++; if (got !== 5 || pending !== 1'b0) begin tests_failed++; $display("FAIL full_no_loss: got resp=%0d pending=%b expected 5/0", got, pending); end
  endtask

  task automatic test_reset_midflight();
    int stale = 0;
    resp_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h70 + c;
      next_cycle();
    end
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clock);
    tests_run++; if ({resp_valid, idle, req_ready} !== 3'b100) begin tests_failed++; $display("FAIL mid_pre_reset: got valid,idle,ready=%b expected 100", {resp_valid, idle, req_ready}); end
    next_cycle();
    rst = 1'b0;
    @(negedge clock);
    tests_run++; if ({resp_valid, idle, req_ready} !== 3'b011) begin tests_failed++; $display("FAIL mid_post_reset: got valid,idle,ready=%b expected 011", {resp_valid, idle, req_ready}); end
    resp_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      @(negedge clock);
      if (resp_valid) stale++;
    end
    next_cycle();
    tests_run++; if (stale !== 0) begin tests_failed++; $display("FAIL mid_stale: got %0d stale responses expected 0", stale); end
  endtask

`ifdef MEM_INIT_WRITE_ACK_EN
  task automatic test_write_ack();
    logic [32:0] exp_resp [3];
    int got = 0;
    exp_resp[0] = {1'b1, 32'h0};
    exp_resp[1] = {1'b0, 32'h12345678};
    exp_resp[2] = {1'b1, 32'h0};
    resp_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      req_valid = (c < 3); req_we = (c != 1); req_addr = 32'h30;
      req_wdata = (c == 0) ? 32'h12345678 : 32'hAAAA5555;
      @(negedge clock);
      if (resp_valid) begin
        tests_run++; if (got > 2 || {resp_is_write, resp_rdata} !== exp_resp[got]) begin tests_failed++; $display("FAIL ack_resp[%0d]: got %b/%h", got, resp_is_write, resp_rdata); end
        got++;
      end
      next_cycle();
    end
    req_valid = 1'b0;
    tests_run++; if (got !== 3) begin tests_failed++; $display("FAIL ack_count: got %0d expected 3", got); end
  endtask
`endif

  task automatic test_no_overflow();
    tests_run++; if (overflow_seen !== 1'b0) begin tests_failed++; $display("FAIL fifo_overflow: got %b expected 0", overflow_seen); end
  endtask

  initial begin
    test_reset();
    test_load_latency();
    test_store_load();
    test_backpressure();
    test_back_to_back();
    test_full_fifo();
    test_reset_midflight();
`ifdef MEM_INIT_WRITE_ACK_EN
    test_write_ack();
`endif
    test_no_overflow();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
